// File: rtl/prescale_gen.sv
// Purpose: CAN-style baud-rate prescaler; one-clock time-quantum pulse every brp_act+1 clocks, divisor changes staged in a shadow.
// Latency: all outputs registered; first pulse brp_act+1 clocks after enable rises from cnt=0.
// Backpressure: none; free-running while enable=1, divisor writes always accepted (last write wins).
module prescale_gen (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       hardsync,
    input  logic       brp_wr,
    input  logic [5:0] brp_data,
    output logic       prescaler,
    output logic [5:0] brp_q,
    output logic       upd_pending
);

    logic [5:0] cnt;
    logic [5:0] brp_act;
    logic [5:0] brp_shadow;
    logic       pend;
    logic       wrap;
    logic       act_pt;
    logic [5:0] next_div;

    // A new divisor may only take effect when the count restarts, so a period never mixes divisors.
    always_comb begin
        wrap     = enable && !hardsync && (cnt == brp_act);
        act_pt   = !enable || hardsync || wrap;
        next_div = brp_wr ? brp_data : brp_shadow;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt        <= 6'd0;
            prescaler  <= 1'b0;
            brp_act    <= 6'd1;
            brp_shadow <= 6'd1;
            pend       <= 1'b0;
        end else begin
            if (!enable || hardsync) begin
                cnt       <= 6'd0;
                prescaler <= 1'b0;
            end else if (wrap) begin
                cnt       <= 6'd0;
                prescaler <= 1'b1;
            end else begin
                cnt       <= cnt + 6'd1;
                prescaler <= 1'b0;
            end

            if (brp_wr)
                brp_shadow <= brp_data;

            if (act_pt) begin
                brp_act <= next_div;
                pend    <= 1'b0;
            end else if (brp_wr) begin
                pend <= 1'b1;
            end
        end
    end

    assign brp_q       = brp_act;
    assign upd_pending = pend;

endmodule

// File: tb/tb_prescale_gen.sv
// Directed bench for prescale_gen: a vector table for the main run plus hand sequences for hardsync and mid-period reset.
module tb_prescale_gen;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       hardsync;
    logic       brp_wr;
    logic [5:0] brp_data;
    logic       prescaler;
    logic [5:0] brp_q;
    logic       upd_pending;

    int n_cmp = 0;
    int n_bad = 0;

    prescale_gen dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .hardsync   (hardsync),
        .brp_wr     (brp_wr),
        .brp_data   (brp_data),
        .prescaler  (prescaler),
        .brp_q      (brp_q),
        .upd_pending(upd_pending)
    );

    always #5 clock = ~clock;

    typedef struct {
        string      tag;
        logic       rst;
        logic       en;
        logic       hs;
        logic       wr;
        logic [5:0] dat;
        logic       exp_p;
        logic [5:0] exp_q;
        logic       exp_u;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string tag, input int n, input logic rst, input logic en,
                       input logic hs, input logic wr, input logic [5:0] dat,
                       input logic p, input logic [5:0] q, input logic u);
        vec_t v;
        v.tag = tag; v.rst = rst; v.en = en; v.hs = hs; v.wr = wr; v.dat = dat;
        v.exp_p = p; v.exp_q = q; v.exp_u = u;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input string tag, input logic rst, input logic en, input logic hs,
                        input logic wr, input logic [5:0] dat,
                        input logic p, input logic [5:0] q, input logic u);
        @(negedge clock);
        reset = rst; enable = en; hardsync = hs; brp_wr = wr; brp_data = dat;
        @(posedge clock);
        #1;
        n_cmp += 3;
        if (prescaler !== p) begin
            n_bad++;
            $display("FAIL %s prescaler got %0b expected %0b at %0t", tag, prescaler, p, $time);
        end
        if (brp_q !== q) begin
            n_bad++;
            $display("FAIL %s brp_q got %0d expected %0d at %0t", tag, brp_q, q, $time);
        end
        if (upd_pending !== u) begin
            n_bad++;
            $display("FAIL %s upd_pending got %0b expected %0b at %0t", tag, upd_pending, u, $time);
        end
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; hardsync = 1'b0; brp_wr = 1'b0; brp_data = 6'd0;

        // reset and period-2 run
        add("reset",        3, 0, 0, 0, 0, 6'd0, 0, 6'd1, 0);
        for (int k = 0; k < 3; k++) begin
            add("p2_low",   1, 1, 1, 0, 0, 6'd0, 0, 6'd1, 0);
            add("p2_pulse", 1, 1, 1, 0, 0, 6'd0, 1, 6'd1, 0);
        end
        // write 4 at cnt=0: old period completes, then period 5
        add("wr4_pend",     1, 1, 1, 0, 1, 6'd4, 0, 6'd1, 1);
        add("wr4_act",      1, 1, 1, 0, 0, 6'd0, 1, 6'd4, 0);
        for (int k = 0; k < 2; k++) begin
            add("p5_low",   4, 1, 1, 0, 0, 6'd0, 0, 6'd4, 0);
            add("p5_pulse", 1, 1, 1, 0, 0, 6'd0, 1, 6'd4, 0);
        end
        // divide-by-1
        add("wr0_pend",     1, 1, 1, 0, 1, 6'd0, 0, 6'd4, 1);
        add("wr0_wait",     3, 1, 1, 0, 0, 6'd0, 0, 6'd4, 1);
        add("wr0_act",      1, 1, 1, 0, 0, 6'd0, 1, 6'd0, 0);
        add("div1",         2, 1, 1, 0, 0, 6'd0, 1, 6'd0, 0);
        add("div1_off",     1, 1, 0, 0, 0, 6'd0, 0, 6'd0, 0);
        // write while disabled activates at once
        add("dis_wr7",      1, 1, 0, 0, 1, 6'd7, 0, 6'd7, 0);
        add("dis_idle",     1, 1, 0, 0, 0, 6'd0, 0, 6'd7, 0);
        add("p8_low",       7, 1, 1, 0, 0, 6'd0, 0, 6'd7, 0);
        add("p8_pulse",     1, 1, 1, 0, 0, 6'd0, 1, 6'd7, 0);
        // two writes before activation: last one wins
        add("lww_wr2",      1, 1, 1, 0, 1, 6'd2, 0, 6'd7, 1);
        add("lww_wr3",      1, 1, 1, 0, 1, 6'd3, 0, 6'd7, 1);
        add("lww_wait",     5, 1, 1, 0, 0, 6'd0, 0, 6'd7, 1);
        add("lww_act",      1, 1, 1, 0, 0, 6'd0, 1, 6'd3, 0);
        add("p4_low",       3, 1, 1, 0, 0, 6'd0, 0, 6'd3, 0);
        add("p4_pulse",     1, 1, 1, 0, 0, 6'd0, 1, 6'd3, 0);
        // write coincident with wrap takes effect in that same cycle
        add("p4_low2",      3, 1, 1, 0, 0, 6'd0, 0, 6'd3, 0);
        add("wrap_wr1",     1, 1, 1, 0, 1, 6'd1, 1, 6'd1, 0);
        add("p2b_low",      1, 1, 1, 0, 0, 6'd0, 0, 6'd1, 0);
        add("p2b_pulse",    1, 1, 1, 0, 0, 6'd0, 1, 6'd1, 0);

        foreach (vecs[i])
            step($sformatf("%s[%0d]", vecs[i].tag, i), vecs[i].rst, vecs[i].en, vecs[i].hs,
                 vecs[i].wr, vecs[i].dat, vecs[i].exp_p, vecs[i].exp_q, vecs[i].exp_u);

        // hardsync at cnt==4 with brp_act=4 suppresses the pulse and restarts the period
        step("hs_rst",     0, 0, 0, 0, 6'd0, 0, 6'd1, 0);
        step("hs_ld4",     1, 0, 0, 1, 6'd4, 0, 6'd4, 0);
        for (int k = 0; k < 4; k++)
            step("hs_cnt",  1, 1, 0, 0, 6'd0, 0, 6'd4, 0);
        step("hs_hit",     1, 1, 1, 0, 6'd0, 0, 6'd4, 0);
        for (int k = 0; k < 4; k++)
            step("hs_after", 1, 1, 0, 0, 6'd0, 0, 6'd4, 0);
        step("hs_pulse",   1, 1, 0, 0, 6'd0, 1, 6'd4, 0);
        // hardsync activates a pending divisor
        step("hs_wr2",     1, 1, 0, 1, 6'd2, 0, 6'd4, 1);
        step("hs_act",     1, 1, 1, 0, 6'd0, 0, 6'd2, 0);
        step("hs_p3a",     1, 1, 0, 0, 6'd0, 0, 6'd2, 0);
        step("hs_p3b",     1, 1, 0, 0, 6'd0, 0, 6'd2, 0);
        step("hs_p3",      1, 1, 0, 0, 6'd0, 1, 6'd2, 0);

        // reset mid-period with brp_act=9 and a pending write discards both
        step("mr_ld9",     1, 0, 0, 1, 6'd9, 0, 6'd9, 0);
        for (int k = 0; k < 4; k++)
            step("mr_cnt",  1, 1, 0, 0, 6'd0, 0, 6'd9, 0);
        step("mr_pend",    1, 1, 0, 1, 6'd2, 0, 6'd9, 1);
        step("mr_reset",   0, 1, 1, 1, 6'd5, 0, 6'd1, 0);
        step("mr_resume",  1, 1, 0, 0, 6'd0, 0, 6'd1, 0);
        step("mr_pulse",   1, 1, 0, 0, 6'd0, 1, 6'd1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
